ldm_sequencer: RTL and testbench

- Multi-cycle block-transfer writer for the ARM core's register file. Executes LDM (LDMIA/IB/DA/DB, optional base writeback) by fetching one word per beat from data memory.
- Drives the register-file write port (A3/WD3/WE3) for each loaded register, then for the base writeback.
- Sits beside the single-cycle datapath. The control unit stalls the datapath while busy=1.

---
 rtl/ldm_sequencer.sv | 172 +++++++++++++++++
 tb/tb_ldm_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ldm_sequencer.sv
// LDM block-transfer sequencer: one data-memory beat per listed register, then an optional base writeback.
// Optional feature macro: LDM_PC_LOAD_EN (honour reg_list[15] and drive pc_load on the R15 beat).
module ldm_sequencer #(
  parameter int DATA_W = 32,
  parameter int STRIDE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] base_addr,
  input  logic [3:0]        rn,
  input  logic [15:0]       reg_list,
  input  logic              up,
  input  logic              pre,
  input  logic              wb,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        A3,
  output logic [DATA_W-1:0] WD3,
  output logic              WE3,
  output logic              pc_load,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WBACK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [DATA_W-1:0] L_STRIDE = DATA_W'(STRIDE);

  logic [1:0]        r_state;
  logic [15:0]       r_list;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_new_base;
  logic [3:0]        r_rn;
  logic              r_wb_en;

  logic [15:0]       w_eff_list;
  logic [15:0]       w_list_next;
  logic [4:0]        w_cnt;
  logic [DATA_W-1:0] w_span;
  logic [DATA_W-1:0] w_start_addr;
  logic [DATA_W-1:0] w_new_base;
  logic [3:0]        w_cur_reg;
  logic              w_pc_beat;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

  // Lowest set index: registers go out in ascending order, lowest to the lowest address.
  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

`ifdef LDM_PC_LOAD_EN
  assign w_eff_list = reg_list;
  assign w_pc_beat  = (w_cur_reg == 4'd15);
`else
  assign w_eff_list = {1'b0, reg_list[14:0]};
  assign w_pc_beat  = 1'b0;
`endif

  assign w_cnt       = popcount16(w_eff_list);
  assign w_span      = DATA_W'(w_cnt) * L_STRIDE;
  assign w_new_base  = up ? (base_addr + w_span) : (base_addr - w_span);
  assign w_cur_reg   = lowest_idx(r_list);
  assign w_list_next = r_list & ~(16'd1 << w_cur_reg);

  // First transfer address for the four addressing modes, keyed on {P,U}.
  always_comb begin
    w_start_addr = base_addr;
    case ({pre, up})
      2'b01:   w_start_addr = base_addr;
      2'b11:   w_start_addr = base_addr + L_STRIDE;
      2'b00:   w_start_addr = base_addr - w_span + L_STRIDE;
      2'b10:   w_start_addr = base_addr - w_span;
      default: w_start_addr = base_addr;
    endcase
  end

  // Sequencer state, latched operands and beat bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_list     <= 16'd0;
      r_addr     <= {DATA_W{1'b0}};
      r_new_base <= {DATA_W{1'b0}};
      r_rn       <= 4'd0;
      r_wb_en    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_list     <= w_eff_list;
            r_addr     <= w_start_addr;
            r_new_base <= w_new_base;
            r_rn       <= rn;
            // A base register that is also loaded keeps the loaded value.
            r_wb_en    <= wb & ~w_eff_list[rn];
            r_state    <= (w_cnt == 5'd0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (mem_ready) begin
            r_list <= w_list_next;
            r_addr <= r_addr + L_STRIDE;
            if (w_list_next == 16'd0) begin
              r_state <= r_wb_en ? S_WBACK : S_DONE;
            end
          end
        end
        S_WBACK: r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Register-file write port and memory request, decoded from state and mem_ready.
  always_comb begin
    mem_req = 1'b0;
    A3      = 4'd0;
    WD3     = {DATA_W{1'b0}};
    WE3     = 1'b0;
    pc_load = 1'b0;
    case (r_state)
      S_LOAD: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          WE3     = 1'b1;
          A3      = w_cur_reg;
          WD3     = mem_rdata;
          pc_load = w_pc_beat;
        end else begin
          WE3     = 1'b0;
        end
      end
      S_WBACK: begin
        WE3 = 1'b1;
        A3  = r_rn;
        WD3 = r_new_base;
      end
      default: begin
        WE3 = 1'b0;
      end
    endcase
  end

  assign mem_addr = r_addr;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_ldm_sequencer.sv
// Directed bench for ldm_sequencer (default build, LDM_PC_LOAD_EN undefined); memory returns addr ^ 0xDEAD0000.
module tb_ldm_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [3:0]  rn;
  logic [15:0] reg_list;
  logic        up, pre, wb;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [3:0]  A3;
  logic [31:0] WD3;
  logic        WE3, pc_load, busy, done;

  int n_cmp = 0;
  int n_mis = 0;
  int wait_n = 0;
  int wcnt = 0;

  logic [31:0] exp_a [8];
  logic [31:0] exp_d [8];
  logic [31:0] exp_b [8];
  int exp_nw, exp_nb, exp_done;

  ldm_sequencer #(.DATA_W(32), .STRIDE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .rn(rn),
    .reg_list(reg_list), .up(up), .pre(pre), .wb(wb),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .A3(A3), .WD3(WD3), .WE3(WE3), .pc_load(pc_load), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory model: wait_n not-ready cycles before every beat.
  always @(posedge clk) begin
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  assign mem_ready = (wcnt >= wait_n);
  assign mem_rdata = mem_addr ^ 32'hDEAD_0000;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_w(input int i, input logic [31:0] a, input logic [31:0] d);
    exp_a[i] = a;
    exp_d[i] = d;
  endtask

  task automatic run_op(input string name, input logic [31:0] base, input logic [3:0] rn_i,
                        input logic [15:0] list, input logic u, input logic p, input logic w,
                        input logic poke);
    logic [31:0] wa [8];
    logic [31:0] wd [8];
    logic [31:0] ba [8];
    logic [31:0] wait_addr;
    logic        was_wait, busy0;
    int n_wr, n_beat, n_req, n_pc, done_cyc, viol, unstable;
    n_wr = 0; n_beat = 0; n_req = 0; n_pc = 0; done_cyc = -1; viol = 0; unstable = 0;
    was_wait = 1'b0; wait_addr = 32'd0; busy0 = 1'b0;
    base_addr = base; rn = rn_i; reg_list = list; up = u; pre = p; wb = w; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 64; c++) begin
      if (c == 0) busy0 = busy;
      if (WE3) begin
        if (n_wr < 8) begin wa[n_wr] = {28'd0, A3}; wd[n_wr] = WD3; end
        n_wr++;
      end
      if (mem_req) begin
        n_req++;
        if (!mem_ready && WE3) viol++;
        if (was_wait && (mem_addr !== wait_addr)) unstable++;
        was_wait = !mem_ready;
        wait_addr = mem_addr;
        if (mem_ready) begin
          if (n_beat < 8) ba[n_beat] = mem_addr;
          n_beat++;
        end
      end
      if (pc_load) n_pc++;
      start = poke && (c == 1);
      if (done) begin
        done_cyc = c;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_val({name, "_busy_first"}, {31'd0, busy0}, 32'd1);
    check_val({name, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    check_val({name, "_n_writes"}, 32'(n_wr), 32'(exp_nw));
    for (int i = 0; i < exp_nw && i < n_wr && i < 8; i++) begin
      check_val($sformatf("%s_wr%0d_A3", name, i), wa[i], exp_a[i]);
      check_val($sformatf("%s_wr%0d_WD3", name, i), wd[i], exp_d[i]);
    end
    check_val({name, "_n_beats"}, 32'(n_beat), 32'(exp_nb));
    for (int i = 0; i < exp_nb && i < n_beat && i < 8; i++) begin
      check_val($sformatf("%s_beat%0d_addr", name, i), ba[i], exp_b[i]);
    end
    check_val({name, "_req_cycles"}, 32'(n_req), 32'(exp_nb * (wait_n + 1)));
    check_val({name, "_we_while_wait"}, 32'(viol), 32'd0);
    check_val({name, "_addr_unstable"}, 32'(unstable), 32'd0);
    check_val({name, "_pc_load"}, 32'(n_pc), 32'd0);
    @(negedge clk);
    check_val({name, "_busy_after"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; base_addr = 32'd0; rn = 4'd0; reg_list = 16'd0;
    up = 1'b0; pre = 1'b0; wb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("reset_mem_addr", mem_addr, 32'd0);
    check_val("reset_wd3", WD3, 32'd0);
    check_val("reset_ctl", {23'd0, mem_req, A3, WE3, pc_load, busy, done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // LDMIA R1!,{R2,R4,R5}, base 0x100; a stray start mid-operation is ignored.
    set_w(0, 32'd2, 32'hDEAD_0100); set_w(1, 32'd4, 32'hDEAD_0104);
    set_w(2, 32'd5, 32'hDEAD_0108); set_w(3, 32'd1, 32'h0000_010C);
    exp_b[0] = 32'h100; exp_b[1] = 32'h104; exp_b[2] = 32'h108;
    exp_nw = 4; exp_nb = 3; exp_done = 4;
    run_op("ia_wb", 32'h100, 4'd1, 16'h0034, 1'b1, 1'b0, 1'b1, 1'b1);

    // Reset asserted while beat 2 is on the bus.
    base_addr = 32'h100; rn = 4'd1; reg_list = 16'h0034; up = 1'b1; pre = 1'b0; wb = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_val("midop_beat2_addr", mem_addr, 32'h104);
    rst = 1'b0;
    #1;
    check_val("midop_rst_addr", mem_addr, 32'd0);
    check_val("midop_rst_wd3", WD3, 32'd0);
    check_val("midop_rst_ctl", {23'd0, mem_req, A3, WE3, pc_load, busy, done}, 32'd0);
    @(negedge clk);
    check_val("midop_rst_hold", {23'd0, mem_req, A3, WE3, pc_load, busy, done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_val("midop_post_idle", {23'd0, mem_req, A3, WE3, pc_load, busy, done}, 32'd0);
    run_op("ia_after_rst", 32'h100, 4'd1, 16'h0034, 1'b1, 1'b0, 1'b1, 1'b0);

    // LDMDB R3!,{R0,R7}, base 0x200.
    set_w(0, 32'd0, 32'hDEAD_01F8); set_w(1, 32'd7, 32'hDEAD_01FC); set_w(2, 32'd3, 32'h0000_01F8);
    exp_b[0] = 32'h1F8; exp_b[1] = 32'h1FC;
    exp_nw = 3; exp_nb = 2; exp_done = 3;
    run_op("db_wb", 32'h200, 4'd3, 16'h0081, 1'b0, 1'b1, 1'b1, 1'b0);

    // LDMIB R1,{R2}, base 0x100, no writeback.
    set_w(0, 32'd2, 32'hDEAD_0104);
    exp_b[0] = 32'h104;
    exp_nw = 1; exp_nb = 1; exp_done = 1;
    run_op("ib_nowb", 32'h100, 4'd1, 16'h0004, 1'b1, 1'b1, 1'b0, 1'b0);

    // LDMDA R6!,{R1,R2}, base 0x80, two wait cycles before each beat.
    wait_n = 2;
    set_w(0, 32'd1, 32'hDEAD_007C); set_w(1, 32'd2, 32'hDEAD_0080); set_w(2, 32'd6, 32'h0000_0078);
    exp_b[0] = 32'h07C; exp_b[1] = 32'h080;
    exp_nw = 3; exp_nb = 2; exp_done = 7;
    run_op("da_wait", 32'h080, 4'd6, 16'h0006, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_n = 0;

    // LDMIA R1!,{R1,R2}, base 0x40: base in list, writeback suppressed.
    set_w(0, 32'd1, 32'hDEAD_0040); set_w(1, 32'd2, 32'hDEAD_0044);
    exp_b[0] = 32'h040; exp_b[1] = 32'h044;
    exp_nw = 2; exp_nb = 2; exp_done = 2;
    run_op("rn_in_list", 32'h040, 4'd1, 16'h0006, 1'b1, 1'b0, 1'b1, 1'b0);

    // LDMDB R5!,{R0,R1,R2}, base 0x4: addresses and new base wrap below zero.
    set_w(0, 32'd0, 32'h2152_FFF8); set_w(1, 32'd1, 32'h2152_FFFC);
    set_w(2, 32'd2, 32'hDEAD_0000); set_w(3, 32'd5, 32'hFFFF_FFF8);
    exp_b[0] = 32'hFFFF_FFF8; exp_b[1] = 32'hFFFF_FFFC; exp_b[2] = 32'h0000_0000;
    exp_nw = 4; exp_nb = 3; exp_done = 4;
    run_op("db_wrap", 32'h004, 4'd5, 16'h0007, 1'b0, 1'b1, 1'b1, 1'b0);

    // Empty list, then a list holding only R15 (masked in this build).
    exp_nw = 0; exp_nb = 0; exp_done = 0;
    run_op("empty", 32'h300, 4'd2, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("r15_masked", 32'h300, 4'd2, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
